uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Command-frame controller behind the UART `Receiver`. It consumes the receiver's byte stream (`data_rx`/`valid`) and sequences it through a framing FSM: sync byte, opcode, length, payload, XOR checksum. Validated commands go to the downstream command executor over a valid/ack handshake. Malformed frames, oversize lengths, inter-byte timeouts and bytes arriving while a command is pending are each flagged with a one-cycle error pulse.

## Interface
- `MAX_LEN`, 8: maximum payload bytes per frame; legal range 1..15.
- `TIMEOUT`, 50000: clk cycles allowed between bytes inside a frame.
- `SYNC`, 8'hA5: frame start byte.

- `clk` input 1: system clock; one clock domain.
- `rst` input 1: reset, synchronous and active-high.
- `rx_data` input 8: byte from `Receiver.data_rx`.
- `rx_valid` input 1: `Receiver.valid` level; a new byte is its 0->1 transition.
- `cmd_ack` input 1: consumer accepts the pending command.
- `cmd_rd_addr` input 4: payload buffer read index.
- `cmd_valid` output 1: command pending; level, held until acked.
- `cmd_op` output 8: opcode of the pending command.
- `cmd_len` output 4: payload length of the pending command.
- `cmd_rd_data` output 8: combinational read `payload[cmd_rd_addr]`; 0 for addr >= MAX_LEN.
- `busy` output 1: FSM not in SYNC.
- `err_chk`, `err_len`, `err_timeout`, `err_ovf` output 1 each: one-cycle error pulses.
- `state` output 3: FSM state, exposed for debugging.

## Operation
- Byte event: `byte_evt = rx_valid & ~rx_valid_q`, where `rx_valid_q` is `rx_valid` registered. `rx_data` is sampled on the same edge.
- `rx_valid_q` resets to 1, so the receiver's reset-time `valid=1` (idle line) is never taken as a byte.
- Frame format: SYNC, OP, LEN, LEN payload bytes, CHK. CHK = XOR of OP, LEN and every payload byte.
- FSM states, encoded SYNC=0, OP=1, LEN=2, PAYLOAD=3, CHK=4. All transitions occur only on `byte_evt` unless noted.
  - SYNC: byte == SYNC -> OP, clear running checksum. Any other byte is silently discarded.
  - OP: store opcode, checksum ^= byte -> LEN.
  - LEN: byte > MAX_LEN -> `err_len`, go to SYNC. byte == 0 -> CHK. Otherwise latch length, index=0 -> PAYLOAD. Each accepted path also does checksum ^= byte.
  - PAYLOAD: `payload[index] <= byte`, checksum ^= byte, index++. After the LEN-th byte -> CHK.
  - CHK: byte == checksum -> `cmd_op`/`cmd_len` updated and `cmd_valid <= 1`. Otherwise `err_chk`. Both outcomes -> SYNC.
- Handshake:
  - `cmd_valid` stays high until sampled with `cmd_ack=1`, then clears on that edge.
  - `cmd_ack` is ignored while `cmd_valid=0`.
  - While `cmd_valid=1`, every `byte_evt` is dropped: FSM stays in SYNC and `err_ovf` pulses per byte. This protects the payload buffer.
  - `cmd_ack` and `byte_evt` on the same edge: ack clears `cmd_valid` and the byte is still dropped with `err_ovf`.
- Timeout:
  - Counter width is clog2(TIMEOUT+1). It counts while state != SYNC and clears on every `byte_evt` and in SYNC.
  - On reaching TIMEOUT-1: `err_timeout` pulses, FSM -> SYNC, partial frame discarded.
  - `byte_evt` and timeout on the same edge: the byte wins and no timeout fires.
- `busy = (state != SYNC)`.

## Timing
- Reset values:
  - `cmd_valid`, all `err_*`, `busy`: 0.
  - `cmd_op`: 0; `cmd_len`: 0; payload buffer: all 0.
  - `state`: SYNC.
  - Checksum, index and timeout counter: 0.
- Reset mid-frame aborts the frame and clears a pending `cmd_valid`. It raises no error pulse.
- Latency: `cmd_valid` rises on the edge after the clock in which `rx_valid` rises for the CHK byte, i.e. one cycle later.
- Error pulses are registered, asserted for exactly one cycle following the offending edge.
- `cmd_op`, `cmd_len` and payload are stable for the whole time `cmd_valid=1`.

## Test plan
- Good frame: A5 12 02 34 56 72 -> `cmd_valid=1` with op=0x12, len=2, rd[0]=0x34, rd[1]=0x56. Holds until `cmd_ack`, clears the cycle after ack.
- Zero-length frame: A5 07 00 07 -> `cmd_valid`, op=0x07, len=0. Bad CHK: A5 12 02 34 56 73 -> `err_chk` pulse, no `cmd_valid`, state SYNC.
- Oversize: A5 01 09 with MAX_LEN=8 -> `err_len` after the LEN byte. Following garbage 33 44 ignored. Next good frame accepted.
- Timeout: A5 12, then TIMEOUT idle cycles -> `err_timeout` pulse, busy=0. A byte arriving exactly at cycle TIMEOUT-1 -> no timeout.
- Overflow: good frame left unacked, then a second frame A5 01 00 01 -> 4 `err_ovf` pulses, first command's op/payload unchanged.
- Reset: assert `rst` with idle-high `rx_valid=1` and mid-PAYLOAD -> no byte event, state SYNC, all outputs at reset values.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: SYNC, OP, LEN, payload, XOR checksum framing behind the UART
// receiver, with a valid/ack command handshake and one-cycle error pulses.
module uart_cmd_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned TIMEOUT = 50000,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       cmd_ack,
  input  logic [3:0] cmd_rd_addr,
  output logic       cmd_valid,
  output logic [7:0] cmd_op,
  output logic [3:0] cmd_len,
  output logic [7:0] cmd_rd_data,
  output logic       busy,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_ovf,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StSync    = 3'd0,
    StOp      = 3'd1,
    StLen     = 3'd2,
    StPayload = 3'd3,
    StChk     = 3'd4
  } state_e;

  localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [3:0]     MaxLen4 = 4'(MAX_LEN);
  localparam logic [7:0]     MaxLen8 = 8'(MAX_LEN);

  state_e          state_q, state_d;
  logic            rx_valid_q;
  logic            byte_evt;
  logic [7:0]      chk_q, chk_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      len_q, len_d;
  logic [7:0]      op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [7:0]      cmd_op_q, cmd_op_d;
  logic [3:0]      cmd_len_q, cmd_len_d;
  logic            err_chk_q, err_chk_d;
  logic            err_len_q, err_len_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_ovf_q, err_ovf_d;
  logic            pl_we;
  logic [7:0]      payload_q [16];

  // rx_valid_q resets high so an idle-high receiver line is never seen as a byte.
  assign byte_evt = rx_valid & ~rx_valid_q;

  always_comb begin
    state_d       = state_q;
    chk_d         = chk_q;
    idx_d         = idx_q;
    len_d         = len_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_op_d      = cmd_op_q;
    cmd_len_d     = cmd_len_q;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_ovf_d     = 1'b0;
    pl_we         = 1'b0;

    if (cmd_valid_q && cmd_ack) begin
      cmd_valid_d = 1'b0;
    end

    if (state_q == StSync || byte_evt) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // A pending command owns the payload buffer, so every incoming byte is dropped.
    if (byte_evt && cmd_valid_q) begin
      err_ovf_d = 1'b1;
    end else if (byte_evt) begin
      unique case (state_q)
        StSync: begin
          if (rx_data == SYNC) begin
            state_d = StOp;
            chk_d   = '0;
          end
        end
        StOp: begin
          op_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = StLen;
        end
        StLen: begin
          if (rx_data > MaxLen8) begin
            err_len_d = 1'b1;
            state_d   = StSync;
          end else begin
            chk_d   = chk_q ^ rx_data;
            len_d   = rx_data[3:0];
            idx_d   = '0;
            state_d = (rx_data == 8'd0) ? StChk : StPayload;
          end
        end
        StPayload: begin
          pl_we = 1'b1;
          chk_d = chk_q ^ rx_data;
          idx_d = idx_q + 4'd1;
          if (idx_q == len_q - 4'd1) begin
            state_d = StChk;
          end
        end
        StChk: begin
          if (rx_data == chk_q) begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = op_q;
            cmd_len_d   = len_q;
          end else begin
            err_chk_d = 1'b1;
          end
          state_d = StSync;
        end
        default: state_d = StSync;
      endcase
    end else if (state_q != StSync && cnt_q == CntLast) begin
      err_timeout_d = 1'b1;
      state_d       = StSync;
      cnt_d         = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StSync;
      rx_valid_q    <= 1'b1;
      chk_q         <= '0;
      idx_q         <= '0;
      len_q         <= '0;
      op_q          <= '0;
      cnt_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_op_q      <= '0;
      cmd_len_q     <= '0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_valid_q    <= rx_valid;
      chk_q         <= chk_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_op_q      <= cmd_op_d;
      cmd_len_q     <= cmd_len_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        payload_q[i] <= '0;
      end
    end else if (pl_we) begin
      payload_q[idx_q] <= rx_data;
    end
  end

  assign cmd_rd_data = (cmd_rd_addr < MaxLen4) ? payload_q[cmd_rd_addr] : 8'h00;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_op      = cmd_op_q;
  assign cmd_len     = cmd_len_q;
  assign busy        = (state_q != StSync);
  assign state       = state_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected commands are queued as frames are sent and
// checked when cmd_valid is seen.
module tb_uart_cmd_ctrl;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned TIMEOUT = 40;
  localparam logic [7:0]  SYNC    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_ack;
  logic [3:0] cmd_rd_addr;
  logic       cmd_valid;
  logic [7:0] cmd_op;
  logic [3:0] cmd_len;
  logic [7:0] cmd_rd_data;
  logic       busy;
  logic       err_chk;
  logic       err_len;
  logic       err_timeout;
  logic       err_ovf;
  logic [2:0] state;

  uart_cmd_ctrl #(
    .MAX_LEN(MAX_LEN),
    .TIMEOUT(TIMEOUT),
    .SYNC   (SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_ack    (cmd_ack),
    .cmd_rd_addr(cmd_rd_addr),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .cmd_rd_data(cmd_rd_data),
    .busy       (busy),
    .err_chk    (err_chk),
    .err_len    (err_len),
    .err_timeout(err_timeout),
    .err_ovf    (err_ovf),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       op;
    logic [3:0]       len;
    logic [15:0][7:0] pl;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_err_chk = 0;
  int   n_err_len = 0;
  int   n_err_to = 0;
  int   n_err_ovf = 0;

  always @(negedge clk) begin
    if (err_chk)     n_err_chk++;
    if (err_len)     n_err_len++;
    if (err_timeout) n_err_to++;
    if (err_ovf)     n_err_ovf++;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [3:0] len,
                            input logic [15:0][7:0] pl, input bit corrupt, input bit push);
    logic [7:0] chk;
    cmd_t       c;
    chk = op ^ {4'h0, len};
    send_byte(SYNC);
    send_byte(op);
    send_byte({4'h0, len});
    for (int i = 0; i < int'(len); i++) begin
      send_byte(pl[i]);
      chk ^= pl[i];
    end
    if (corrupt) chk ^= 8'h01;
    if (push && !corrupt) begin
      c.op  = op;
      c.len = len;
      c.pl  = '0;
      for (int i = 0; i < int'(len); i++) c.pl[i] = pl[i];
      exp_q.push_back(c);
    end
    send_byte(chk);
  endtask

  // Pops the scoreboard, compares the pending command, then acks it (optionally with a byte).
  task automatic drain(input string name, input bit with_byte);
    cmd_t c;
    int   waited = 0;
    while (cmd_valid !== 1'b1 && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s cmd_valid: got %b want 1", name, cmd_valid);
      return;
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: got cmd op=%h want no command", name, cmd_op);
      return;
    end
    c = exp_q.pop_front();
    n_checks++;
    if (cmd_op !== c.op) begin
      n_fail++;
      $display("FAIL %s cmd_op: got %h want %h", name, cmd_op, c.op);
    end
    n_checks++;
    if (cmd_len !== c.len) begin
      n_fail++;
      $display("FAIL %s cmd_len: got %0d want %0d", name, cmd_len, c.len);
    end
    for (int i = 0; i < 16; i++) begin
      cmd_rd_addr = 4'(i);
      #1;
      if (i < int'(c.len)) begin
        n_checks++;
        if (cmd_rd_data !== c.pl[i]) begin
          n_fail++;
          $display("FAIL %s rd[%0d]: got %h want %h", name, i, cmd_rd_data, c.pl[i]);
        end
      end else if (i >= int'(MAX_LEN)) begin
        n_checks++;
        if (cmd_rd_data !== 8'h00) begin
          n_fail++;
          $display("FAIL %s rd[%0d] out of range: got %h want 00", name, i, cmd_rd_data);
        end
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s hold: cmd_valid got %b want 1", name, cmd_valid);
    end
    cmd_ack = 1'b1;
    if (with_byte) begin
      rx_data  = SYNC;
      rx_valid = 1'b1;
    end
    @(posedge clk); #1;
    cmd_ack  = 1'b0;
    rx_valid = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ack clear: cmd_valid got %b want 0", name, cmd_valid);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    rx_valid    = 1'b1;
    rx_data     = SYNC;
    cmd_ack     = 1'b0;
    cmd_rd_addr = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({cmd_valid, busy, err_chk, err_len, err_timeout, err_ovf} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset flags: got %b want 000000",
               {cmd_valid, busy, err_chk, err_len, err_timeout, err_ovf});
    end
    n_checks++;
    if (state !== 3'd0 || cmd_op !== 8'h00 || cmd_len !== 4'd0 || cmd_rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset values: got state=%0d op=%h len=%0d rd=%h want 0 00 0 00",
               state, cmd_op, cmd_len, cmd_rd_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset idle-high valid: state got %0d want 0", state);
    end
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    logic [15:0][7:0] pl;
    pl    = '0;
    pl[0] = 8'h34;
    pl[1] = 8'h56;
    send_frame(8'h12, 4'd2, pl, 1'b0, 1'b1);
    drain("good_frame", 1'b0);
    pl = '0;
    send_frame(8'h07, 4'd0, pl, 1'b0, 1'b1);
    drain("zero_len", 1'b0);
  endtask

  task automatic test_bad_chk();
    logic [15:0][7:0] pl;
    int               e;
    pl    = '0;
    pl[0] = 8'h34;
    pl[1] = 8'h56;
    e     = n_err_chk;
    send_frame(8'h12, 4'd2, pl, 1'b1, 1'b0);
    n_checks++;
    if (n_err_chk !== e + 1 || cmd_valid !== 1'b0 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL bad_chk: got pulses=%0d valid=%b state=%0d want 1 0 0",
               n_err_chk - e, cmd_valid, state);
    end
  endtask

  task automatic test_oversize();
    logic [15:0][7:0] pl;
    int               e;
    e = n_err_len;
    send_byte(SYNC);
    send_byte(8'h01);
    n_checks++;
    if (state !== 3'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize pre: got state=%0d busy=%b want 2 1", state, busy);
    end
    send_byte(8'h09);
    n_checks++;
    if (n_err_len !== e + 1 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL oversize err_len: got pulses=%0d state=%0d want 1 0", n_err_len - e, state);
    end
    send_byte(8'h33);
    send_byte(8'h44);
    n_checks++;
    if (state !== 3'd0 || n_err_len !== e + 1) begin
      n_fail++;
      $display("FAIL oversize garbage: got state=%0d pulses=%0d want 0 1", state, n_err_len - e);
    end
    pl    = '0;
    pl[0] = 8'hAB;
    send_frame(8'h03, 4'd1, pl, 1'b0, 1'b1);
    drain("after_oversize", 1'b0);
  endtask

  task automatic test_timeout();
    cmd_t c;
    int   e;
    e = n_err_to;
    send_byte(SYNC);
    send_byte(8'h12);
    repeat (TIMEOUT - 2) @(posedge clk);
    #1;
    n_checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout early: got err=%b busy=%b want 0 1", err_timeout, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout fire: got err=%b busy=%b want 1 0", err_timeout, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (err_timeout !== 1'b0 || n_err_to !== e + 1) begin
      n_fail++;
      $display("FAIL timeout pulse width: got err=%b pulses=%0d want 0 1", err_timeout, n_err_to - e);
    end
    // Byte landing on the very edge the timeout would fire.
    send_byte(SYNC);
    send_byte(8'h12);
    repeat (TIMEOUT - 2) @(posedge clk);
    #1;
    rx_data  = 8'h02;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    n_checks++;
    if (err_timeout !== 1'b0 || state !== 3'd3) begin
      n_fail++;
      $display("FAIL timeout boundary: got err=%b state=%0d want 0 3", err_timeout, state);
    end
    @(posedge clk); #1;
    send_byte(8'h34);
    send_byte(8'h56);
    c.op    = 8'h12;
    c.len   = 4'd2;
    c.pl    = '0;
    c.pl[0] = 8'h34;
    c.pl[1] = 8'h56;
    exp_q.push_back(c);
    send_byte(8'h72);
    drain("timeout_boundary", 1'b0);
  endtask

  task automatic test_overflow();
    logic [15:0][7:0] pl;
    int               e;
    pl    = '0;
    pl[0] = 8'h34;
    pl[1] = 8'h56;
    send_frame(8'h12, 4'd2, pl, 1'b0, 1'b1);
    e = n_err_ovf;
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    n_checks++;
    if (n_err_ovf !== e + 4 || state !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow: got pulses=%0d state=%0d busy=%b want 4 0 0",
               n_err_ovf - e, state, busy);
    end
    drain("overflow_kept", 1'b0);
    // Ack and byte on the same edge: ack wins, byte still dropped.
    pl[0] = 8'h99;
    send_frame(8'h5A, 4'd1, pl, 1'b0, 1'b1);
    e = n_err_ovf;
    drain("ack_collision", 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (n_err_ovf !== e + 1 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL ack_collision drop: got pulses=%0d state=%0d want 1 0", n_err_ovf - e, state);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0][7:0] pl;
    int               e;
    for (int i = 0; i < 16; i++) pl[i] = 8'(8'h11 * (i + 1) + $urandom_range(0, 3));
    send_frame(8'hC3, 4'(MAX_LEN), pl, 1'b0, 1'b1);
    drain("max_len", 1'b0);
    send_frame(8'h3C, 4'd1, pl, 1'b0, 1'b1);
    drain("back_to_back", 1'b0);
    e = n_err_len;
    send_byte(SYNC);
    send_byte(8'h44);
    send_byte(8'h0F);
    n_checks++;
    if (n_err_len !== e + 1 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL len15: got pulses=%0d state=%0d want 1 0", n_err_len - e, state);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0][7:0] pl;
    int               e;
    pl    = '0;
    pl[0] = 8'h11;
    pl[1] = 8'h22;
    send_frame(8'h66, 4'd2, pl, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset pending: cmd_valid got %b want 0", cmd_valid);
    end
    @(posedge clk); #1;
    e = n_err_chk + n_err_len + n_err_to + n_err_ovf;
    send_byte(SYNC);
    send_byte(8'h12);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    n_checks++;
    if (state !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_mid pre: state got %0d want 3", state);
    end
    rx_data  = SYNC;
    rx_valid = 1'b1;
    rst      = 1'b1;
    cmd_rd_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (state !== 3'd0 || busy !== 1'b0 || cmd_op !== 8'h00 || cmd_rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid values: got state=%0d busy=%b op=%h rd=%h want 0 0 00 00",
               state, busy, cmd_op, cmd_rd_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 3'd0 || n_err_chk + n_err_len + n_err_to + n_err_ovf !== e) begin
      n_fail++;
      $display("FAIL reset_mid after: got state=%0d errs=%0d want 0 0",
               state, n_err_chk + n_err_len + n_err_to + n_err_ovf - e);
    end
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_oversize();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
